// File: rtl/core_boot_controller.sv
// Boot sequencer for one RISC-V core: streams a program image into the core's ISP port while
// holding it in reset, then releases reset, pulses start and supervises the run.
module core_boot_controller #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDRESS_BITS   = 12,
   parameter int unsigned PROG_ADDR_BITS = 20,
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [DATA_WIDTH-1:0]     load_data,
   input  logic                      load_last,
   input  logic [ADDRESS_BITS-1:0]   load_base,
   input  logic [PROG_ADDR_BITS-1:0] entry_address,
   input  logic                      done_in,
   input  logic                      restart,
   output logic                      core_reset,
   output logic                      core_start,
   output logic [PROG_ADDR_BITS-1:0] core_prog_address,
   output logic                      isp_write,
   output logic [ADDRESS_BITS-1:0]   isp_address,
   output logic [DATA_WIDTH-1:0]     isp_data,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout,
   output logic                      overflow,
   output logic [ADDRESS_BITS:0]     word_count,
   output logic [31:0]               run_cycles
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRelease,
      StStart,
      StRun,
      StDone
   } state_e;

   localparam int unsigned CountW = ADDRESS_BITS + 1;
   localparam logic [ADDRESS_BITS:0] WordCountMax = {1'b1, {ADDRESS_BITS{1'b0}}};
   localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
   localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

   state_e                    state_q;
   logic [ADDRESS_BITS-1:0]   addr_q;
   logic                      core_reset_q;
   logic                      core_start_q;
   logic [PROG_ADDR_BITS-1:0] core_prog_address_q;
   logic                      isp_write_q;
   logic [ADDRESS_BITS-1:0]   isp_address_q;
   logic [DATA_WIDTH-1:0]     isp_data_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      timeout_q;
   logic                      overflow_q;
   logic [ADDRESS_BITS:0]     word_count_q;
   logic [31:0]               run_cycles_q;

   logic                      accept_state;
   logic                      handshake;
   logic [ADDRESS_BITS-1:0]   wr_addr;
   logic                      run_expired;

   // Ready is held low during reset and during a restart cycle so no word is consumed then.
   assign accept_state = (state_q == StIdle) || (state_q == StLoad);
   assign load_ready   = reset & accept_state & ~restart;
   assign handshake    = load_valid & load_ready;
   assign wr_addr      = (state_q == StIdle) ? load_base : addr_q;
   assign run_expired  = TimeoutEn && (run_cycles_q == TimeoutLast);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q             <= StIdle;
         addr_q              <= '0;
         core_reset_q        <= 1'b1;
         core_start_q        <= 1'b0;
         core_prog_address_q <= '0;
         isp_write_q         <= 1'b0;
         isp_address_q       <= '0;
         isp_data_q          <= '0;
         busy_q              <= 1'b0;
         done_q              <= 1'b0;
         timeout_q           <= 1'b0;
         overflow_q          <= 1'b0;
         word_count_q        <= '0;
         run_cycles_q        <= '0;
      end else begin
         isp_write_q  <= 1'b0;
         core_start_q <= 1'b0;
         if (restart) begin
            state_q             <= StIdle;
            addr_q              <= '0;
            core_reset_q        <= 1'b1;
            core_prog_address_q <= '0;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            timeout_q           <= 1'b0;
            overflow_q          <= 1'b0;
            word_count_q        <= '0;
            run_cycles_q        <= '0;
         end else begin
            if (handshake) begin
               isp_write_q   <= 1'b1;
               isp_address_q <= wr_addr;
               isp_data_q    <= load_data;
               addr_q        <= wr_addr + ADDRESS_BITS'(1);
               // Past saturation the word is still written (at the wrapped address).
               if (word_count_q == WordCountMax) begin
                  overflow_q <= 1'b1;
               end else begin
                  word_count_q <= word_count_q + CountW'(1);
               end
               if (load_last) begin
                  core_prog_address_q <= entry_address;
               end
            end
            unique case (state_q)
               StIdle, StLoad: begin
                  if (handshake) begin
                     busy_q  <= 1'b1;
                     state_q <= load_last ? StRelease : StLoad;
                  end
               end
               StRelease: begin
                  state_q      <= StStart;
                  core_reset_q <= 1'b0;
                  core_start_q <= 1'b1;
               end
               StStart: begin
                  state_q <= StRun;
               end
               StRun: begin
                  run_cycles_q <= run_cycles_q + 32'd1;
                  if (done_in) begin
                     state_q      <= StDone;
                     done_q       <= 1'b1;
                     core_reset_q <= 1'b1;
                     busy_q       <= 1'b0;
                  end else if (run_expired) begin
                     state_q      <= StDone;
                     timeout_q    <= 1'b1;
                     core_reset_q <= 1'b1;
                     busy_q       <= 1'b0;
                  end
               end
               StDone: begin
                  state_q <= StDone;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign core_reset        = core_reset_q;
   assign core_start        = core_start_q;
   assign core_prog_address = core_prog_address_q;
   assign isp_write         = isp_write_q;
   assign isp_address       = isp_address_q;
   assign isp_data          = isp_data_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign timeout           = timeout_q;
   assign overflow          = overflow_q;
   assign word_count        = word_count_q;
   assign run_cycles        = run_cycles_q;

endmodule

// File: tb/tb_core_boot_controller.sv
// Self-checking bench for core_boot_controller: vector table plus randomized loads/runs,
// with an address/data/cycle scoreboard on the ISP port and hand sequences for abort cases.
module tb_core_boot_controller;

   localparam int unsigned DW        = 32;
   localparam int unsigned AB        = 12;
   localparam int unsigned PW        = 20;
   localparam int unsigned TO        = 100;
   localparam int unsigned MEM_WORDS = 1 << AB;

   logic          clock;
   logic          reset;
   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_data;
   logic          load_last;
   logic [AB-1:0] load_base;
   logic [PW-1:0] entry_address;
   logic          done_in;
   logic          restart;
   logic          core_reset;
   logic          core_start;
   logic [PW-1:0] core_prog_address;
   logic          isp_write;
   logic [AB-1:0] isp_address;
   logic [DW-1:0] isp_data;
   logic          busy;
   logic          done;
   logic          timeout;
   logic          overflow;
   logic [AB:0]   word_count;
   logic [31:0]   run_cycles;

   core_boot_controller #(
      .DATA_WIDTH    (DW),
      .ADDRESS_BITS  (AB),
      .PROG_ADDR_BITS(PW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .load_valid       (load_valid),
      .load_ready       (load_ready),
      .load_data        (load_data),
      .load_last        (load_last),
      .load_base        (load_base),
      .entry_address    (entry_address),
      .done_in          (done_in),
      .restart          (restart),
      .core_reset       (core_reset),
      .core_start       (core_start),
      .core_prog_address(core_prog_address),
      .isp_write        (isp_write),
      .isp_address      (isp_address),
      .isp_data         (isp_data),
      .busy             (busy),
      .done             (done),
      .timeout          (timeout),
      .overflow         (overflow),
      .word_count       (word_count),
      .run_cycles       (run_cycles)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned cyc     = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
   endtask

   typedef struct {
      int unsigned   cyc;
      logic [AB-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_wr[$];

   // Every ISP write must match the oldest outstanding handshake, one cycle after it.
   always @(negedge clock) begin
      wr_t e;
      if (reset && isp_write) begin
         if (exp_wr.size() == 0) begin
            chk("isp_unexpected_write", isp_write, 1'b0);
         end else begin
            e = exp_wr.pop_front();
            chk("isp_cycle", cyc, e.cyc);
            chk("isp_addr", isp_address, e.addr);
            chk("isp_data", isp_data, e.data);
         end
      end
   end

   typedef struct {
      logic [AB-1:0] base;
      int unsigned   n;
      logic [PW-1:0] entry;
      int unsigned   mode;     // 0 continuous valid, 1 toggling valid, 2 random valid
      int unsigned   done_at;  // RUN cycle carrying done_in; 0 or > TO means never
      int unsigned   exp_wc;
      bit            exp_ovf;
      bit            exp_done;
      bit            exp_tmo;
      int unsigned   exp_rc;
   } vec_t;

   vec_t tbl[6];

   // Outcome of a load/run from the block's rules, independent of its state machine.
   function automatic vec_t with_model(input vec_t v);
      vec_t r;
      r         = v;
      r.exp_wc  = (v.n > MEM_WORDS) ? MEM_WORDS : v.n;
      r.exp_ovf = (v.n > MEM_WORDS);
      if (v.done_at != 0 && v.done_at <= TO) begin
         r.exp_done = 1'b1;
         r.exp_tmo  = 1'b0;
         r.exp_rc   = v.done_at;
      end else begin
         r.exp_done = 1'b0;
         r.exp_tmo  = 1'b1;
         r.exp_rc   = TO;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] word_of(input int unsigned i, input logic [AB-1:0] base);
      case (i)
         0:       return 32'h0000_0013;
         1:       return 32'h0010_0093;
         2:       return 32'h00A0_0513;
         3:       return 32'h0000_006F;
         default: return (i * 32'h9E37_79B9) ^ {20'h0, base};
      endcase
   endfunction

   task automatic check_cleared(input string tag);
      chk({tag, "_core_reset"}, core_reset, 1'b1);
      chk({tag, "_core_start"}, core_start, 1'b0);
      chk({tag, "_isp_write"}, isp_write, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_timeout"}, timeout, 1'b0);
      chk({tag, "_overflow"}, overflow, 1'b0);
      chk({tag, "_word_count"}, word_count, 0);
      chk({tag, "_run_cycles"}, run_cycles, 0);
      chk({tag, "_prog_addr"}, core_prog_address, 0);
   endtask

   // Offers v.n words; returns right after the sampling point of the final handshake cycle.
   task automatic load_words(input vec_t v, input bit with_last);
      int unsigned i      = 0;
      int unsigned budget = 0;
      bit          tog    = 1'b1;
      wr_t         e;
      while (i < v.n) begin
         @(posedge clock);
         #1;
         case (v.mode)
            0:       load_valid = 1'b1;
            1:       begin load_valid = tog; tog = ~tog; end
            default: load_valid = 1'($urandom_range(0, 1));
         endcase
         load_data     = load_valid ? word_of(i, v.base) : $urandom;
         load_last     = with_last && (i == v.n - 1);
         load_base     = (i == 0) ? v.base : AB'($urandom);
         entry_address = load_last ? v.entry : PW'($urandom);
         @(negedge clock);
         chk("ready_in_load", load_ready, 1'b1);
         if (load_valid && load_ready) begin
            e.cyc  = cyc + 1;
            e.addr = AB'((v.base + i) % MEM_WORDS);
            e.data = load_data;
            exp_wr.push_back(e);
            i++;
         end
         budget++;
         if (budget > 4 * v.n + 16) begin
            chk("load_cycle_budget", budget, 0);
            break;
         end
      end
   endtask

   task automatic do_restart(input string tag);
      @(posedge clock);
      #1;
      restart    = 1'b1;
      load_valid = 1'b1;
      @(negedge clock);
      chk({tag, "_ready_during_restart"}, load_ready, 1'b0);
      @(posedge clock);
      #1;
      restart    = 1'b0;
      load_valid = 1'b0;
      @(negedge clock);
      check_cleared(tag);
      chk({tag, "_ready_idle"}, load_ready, 1'b1);
   endtask

   task automatic run_case(input vec_t v);
      int unsigned end_k;
      load_words(v, 1'b1);
      @(posedge clock);
      #1;
      load_valid    = 1'b0;
      load_last     = 1'b0;
      load_base     = AB'($urandom);
      entry_address = PW'($urandom);
      done_in       = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("release_busy", busy, 1'b1);
      chk("release_core_reset", core_reset, 1'b1);
      chk("release_start", core_start, 1'b0);
      chk("release_ready", load_ready, 1'b0);
      chk("release_prog_addr", core_prog_address, v.entry);
      @(posedge clock);
      #1;
      done_in = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("start_pulse", core_start, 1'b1);
      chk("start_core_reset", core_reset, 1'b0);
      chk("start_ready", load_ready, 1'b0);
      chk("start_prog_addr", core_prog_address, v.entry);
      chk("writes_drained", exp_wr.size(), 0);
      end_k = (v.done_at >= 1 && v.done_at <= TO) ? v.done_at : TO;
      for (int unsigned k = 1; k <= end_k; k++) begin
         @(posedge clock);
         #1;
         done_in = (k == v.done_at);
         @(negedge clock);
         chk("run_core_reset", core_reset, 1'b0);
         chk("run_start", core_start, 1'b0);
         chk("run_busy", busy, 1'b1);
         chk("run_cycles_in_run", run_cycles, k - 1);
      end
      @(posedge clock);
      #1;
      done_in = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("end_done", done, v.exp_done);
      chk("end_timeout", timeout, v.exp_tmo);
      chk("end_run_cycles", run_cycles, v.exp_rc);
      chk("end_word_count", word_count, v.exp_wc);
      chk("end_overflow", overflow, v.exp_ovf);
      chk("end_core_reset", core_reset, 1'b1);
      chk("end_busy", busy, 1'b0);
      chk("end_ready", load_ready, 1'b0);
      chk("end_prog_addr", core_prog_address, v.entry);
      repeat (3) begin
         @(posedge clock);
         #1;
         done_in = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      chk("hold_done", done, v.exp_done);
      chk("hold_run_cycles", run_cycles, v.exp_rc);
      chk("hold_core_reset", core_reset, 1'b1);
      done_in = 1'b0;
      do_restart("after_run");
   endtask

   initial begin
      vec_t v;
      reset         = 1'b0;
      restart       = 1'b0;
      load_valid    = 1'b0;
      load_last     = 1'b0;
      load_data     = '0;
      load_base     = '0;
      entry_address = '0;
      done_in       = 1'b0;

      #12;
      check_cleared("por");
      chk("por_ready", load_ready, 1'b0);
      chk("por_isp_addr", isp_address, 0);
      chk("por_isp_data", isp_data, 0);
      @(negedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check_cleared("idle");
      chk("idle_ready", load_ready, 1'b1);

      //          base     n     entry     mode done wc    ovf  done tmo  rc
      tbl[0] = '{12'h010, 4,    20'h00040, 0, 0,   4,    1'b0, 1'b0, 1'b1, 100};
      tbl[1] = '{12'h010, 4,    20'h00040, 1, 37,  4,    1'b0, 1'b1, 1'b0, 37};
      tbl[2] = '{12'h010, 4,    20'h00040, 0, 100, 4,    1'b0, 1'b1, 1'b0, 100};
      tbl[3] = '{12'hFFE, 3,    20'h00123, 1, 101, 3,    1'b0, 1'b0, 1'b1, 100};
      tbl[4] = '{12'h000, 4097, 20'h00080, 0, 5,   4096, 1'b1, 1'b1, 1'b0, 5};
      tbl[5] = '{12'h007, 1,    20'hFFFFF, 0, 1,   1,    1'b0, 1'b1, 1'b0, 1};
      for (int t = 0; t < 6; t++) run_case(tbl[t]);

      for (int r = 0; r < 6; r++) begin
         v.base    = AB'($urandom);
         v.n       = $urandom_range(1, 12);
         v.entry   = PW'($urandom);
         v.mode    = 2;
         v.done_at = $urandom_range(0, TO + 10);
         run_case(with_model(v));
      end

      // Restart mid-load with a word offered in the same cycle.
      v         = tbl[0];
      v.base    = 12'h100;
      v.n       = 3;
      load_words(v, 1'b0);
      @(posedge clock);
      #1;
      restart    = 1'b1;
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      @(negedge clock);
      chk("midload_ready_during_restart", load_ready, 1'b0);
      @(posedge clock);
      #1;
      restart    = 1'b0;
      load_valid = 1'b0;
      @(negedge clock);
      chk("midload_no_write", isp_write, 1'b0);
      check_cleared("midload");
      chk("midload_ready_idle", load_ready, 1'b1);
      chk("midload_writes_drained", exp_wr.size(), 0);

      // Asynchronous reset while the core is running.
      v      = tbl[0];
      v.base = 12'h3F0;
      v.n    = 2;
      load_words(v, 1'b1);
      @(posedge clock);
      #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("pre_reset_in_run", core_reset, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_cleared("async_reset");
      chk("async_reset_ready", load_ready, 1'b0);
      chk("async_reset_isp_addr", isp_address, 0);
      chk("async_reset_isp_data", isp_data, 0);
      @(negedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check_cleared("post_reset_idle");
      chk("post_reset_writes_drained", exp_wr.size(), 0);
      run_case(tbl[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
